// File: rtl/hid_report_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : hid_report_stream_if
//  Description : Byte-wide interrupt-endpoint bus between the HID report
//                engine and the USB full-speed core.
//                IN  endpoint : ep_in_data / ep_in_valid (engine -> core),
//                               ep_in_ready (core -> engine)
//                OUT endpoint : ep_out_data / ep_out_valid (core -> engine)
//                Modports     : master = report engine, slave = USB core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hid_report_stream_if;
  logic [7:0] ep_in_data;
  logic       ep_in_valid;
  logic       ep_in_ready;
  logic [7:0] ep_out_data;
  logic       ep_out_valid;

  modport master (
    output ep_in_data,
    output ep_in_valid,
    input  ep_in_ready,
    input  ep_out_data,
    input  ep_out_valid
  );

  modport slave (
    input  ep_in_data,
    input  ep_in_valid,
    output ep_in_ready,
    output ep_out_data,
    output ep_out_valid
  );
endinterface
`default_nettype wire

// File: rtl/hid_report_stream.sv
`default_nettype none
// ============================================================================
//  Module      : hid_report_stream
//  Description : HID report engine for NUM_PORTS controller ports.
//                IN path : shadows the controller payload vector and streams
//                          one framed report (ID byte + payload) per USB frame
//                          over the ep_in valid/ready handshake.
//                OUT path: collects a frame-aligned OUT report and turns it
//                          into per-port rumble enables, pulsing out_err on a
//                          bad report ID.
//  Ports       : clk, usb_rstn (async, active-low), sof, report_data,
//                report_update, ep (hid_report_stream_if.master),
//                rumble, in_busy, in_pkt_count, out_err
//  Options     : HID_RUMBLE_WATCHDOG_EN - clear rumble after
//                RUMBLE_TIMEOUT_FRAMES frames without a valid OUT report.
//  Revision    : 1.0 - initial release
// ============================================================================
module hid_report_stream #(
  parameter int         NUM_PORTS             = 4,
  parameter int         PORT_BYTES            = 9,
  parameter logic [7:0] IN_REPORT_ID          = 8'h21,
  parameter logic [7:0] OUT_REPORT_ID         = 8'h11,
  parameter int         RUMBLE_TIMEOUT_FRAMES = 16
) (
  input  wire logic                              clk,
  input  wire logic                              usb_rstn,
  input  wire logic                              sof,
  input  wire logic [NUM_PORTS*PORT_BYTES*8-1:0] report_data,
  input  wire logic                              report_update,
  hid_report_stream_if.master                    ep,
  output logic      [NUM_PORTS-1:0]              rumble,
  output logic                                   in_busy,
  output logic      [15:0]                       in_pkt_count,
  output logic                                   out_err
);

  localparam int PAY_BYTES = NUM_PORTS * PORT_BYTES;
  localparam int PAY_W     = PAY_BYTES * 8;
  localparam int IN_LEN    = 1 + PAY_BYTES;
  localparam int OUT_LEN   = 1 + NUM_PORTS;
  localparam int IDX_W     = $clog2(IN_LEN);
  localparam int SEL_N     = 2 ** IDX_W;
  localparam int OC_W      = $clog2(OUT_LEN + 1);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(IN_LEN - 1);
  localparam logic [OC_W-1:0]  c_out_len  = OC_W'(OUT_LEN);

  // Reject configurations outside the supported range at elaboration.
  generate
    if (NUM_PORTS < 1 || NUM_PORTS > 8 || PORT_BYTES < 1 || PORT_BYTES > 16 ||
        RUMBLE_TIMEOUT_FRAMES < 1) begin : g_bad_cfg
      $error("hid_report_stream: parameter out of range");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // IN path
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            r_state;
  logic [PAY_W-1:0]  r_shadow;
  logic [PAY_W-1:0]  r_snapshot;
  logic [IDX_W-1:0]  r_idx;
  logic              r_pending;
  logic [7:0]        r_in_data;
  logic              r_in_valid;
  logic              r_busy;
  logic [15:0]       r_pkt_count;

  // Snapshot viewed as bytes, byte 0 = port 0 MSB. Padded to a power of two
  // so the index register can address it without a range check.
  logic [7:0] w_snap_byte [SEL_N];

  generate
    for (genvar k = 0; k < SEL_N; k++) begin : g_snap_byte
      if (k < PAY_BYTES) begin : g_used
        assign w_snap_byte[k] = r_snapshot[PAY_W-1-8*k -: 8];
      end else begin : g_pad
        assign w_snap_byte[k] = 8'h00;
      end
    end
  endgenerate

  // r_idx is the report byte currently on ep_in_data; the byte after report
  // byte i is payload byte i, preloaded into r_in_data on acceptance.
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      r_state     <= ST_IDLE;
      r_shadow    <= '0;
      r_snapshot  <= '0;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_in_data   <= 8'h00;
      r_in_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_pkt_count <= 16'h0000;
    end else begin
      if (report_update) begin
        r_shadow <= report_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (sof || r_pending) begin
            r_state    <= ST_SEND;
            // A coincident update bypasses the shadow so the packet carries it.
            r_snapshot <= report_update ? report_data : r_shadow;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_in_data  <= IN_REPORT_ID;
            r_in_valid <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_SEND: begin
          // Frames arriving mid-packet collapse into one pending request.
          if (sof) begin
            r_pending <= 1'b1;
          end
          if (r_in_valid && ep.ep_in_ready) begin
            if (r_idx == c_last_idx) begin
              r_state     <= ST_IDLE;
              r_in_valid  <= 1'b0;
              r_busy      <= 1'b0;
              r_pkt_count <= r_pkt_count + 16'd1;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_in_data <= w_snap_byte[r_idx];
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ep.ep_in_data  = r_in_data;
  assign ep.ep_in_valid = r_in_valid;
  assign in_busy        = r_busy;
  assign in_pkt_count   = r_pkt_count;

  // --------------------------------------------------------------------------
  // OUT path
  // --------------------------------------------------------------------------
  logic [OC_W-1:0]      r_out_cnt;
  logic [7:0]           r_out_id;
  logic [NUM_PORTS-1:0] r_out_bits;
  logic                 r_eval;
  logic                 r_out_err;
  logic [NUM_PORTS-1:0] r_rumble;

  logic            w_wr_en;
  logic [OC_W-1:0] w_wr_idx;
  logic            w_apply;

  // A byte arriving with sof is byte 0 of the new frame.
  assign w_wr_en  = ep.ep_out_valid && (sof || (r_out_cnt < c_out_len));
  assign w_wr_idx = sof ? '0 : r_out_cnt;
  assign w_apply  = r_eval && (r_out_id == OUT_REPORT_ID);

`ifdef HID_RUMBLE_WATCHDOG_EN
  localparam int WD_W = $clog2(RUMBLE_TIMEOUT_FRAMES + 1);
  localparam logic [WD_W-1:0] c_wd_max = WD_W'(RUMBLE_TIMEOUT_FRAMES);
  logic [WD_W-1:0] r_wd_cnt;
`endif

  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      r_out_cnt  <= '0;
      r_out_id   <= 8'h00;
      r_out_bits <= '0;
      r_eval     <= 1'b0;
      r_out_err  <= 1'b0;
      r_rumble   <= '0;
`ifdef HID_RUMBLE_WATCHDOG_EN
      r_wd_cnt   <= '0;
`endif
    end else begin
      if (sof) begin
        r_out_cnt <= ep.ep_out_valid ? OC_W'(1) : '0;
      end else if (w_wr_en) begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end

      if (w_wr_en && (w_wr_idx == '0)) begin
        r_out_id <= ep.ep_out_data;
      end
      // Only bit 0 of each per-port byte matters.
      for (int k = 1; k < OUT_LEN; k++) begin
        if (w_wr_en && (w_wr_idx == OC_W'(k))) begin
          r_out_bits[k-1] <= ep.ep_out_data[0];
        end
      end

      r_eval    <= w_wr_en && (w_wr_idx == OC_W'(OUT_LEN - 1));
      r_out_err <= r_eval && (r_out_id != OUT_REPORT_ID);

`ifdef HID_RUMBLE_WATCHDOG_EN
      // A valid report on the terminal frame takes priority over the timeout.
      if (w_apply) begin
        r_rumble <= r_out_bits;
        r_wd_cnt <= '0;
      end else if (sof && (r_wd_cnt != c_wd_max)) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
        if (r_wd_cnt == c_wd_max - 1'b1) begin
          r_rumble <= '0;
        end
      end
`else
      if (w_apply) begin
        r_rumble <= r_out_bits;
      end
`endif
    end
  end

  assign rumble  = r_rumble;
  assign out_err = r_out_err;

endmodule
`default_nettype wire

// File: doc/hid_report_stream.md
Name: hid_report_stream

Overview:
Parametrised HID report engine between controller-poll logic and a USB full-speed core's interrupt endpoints.
- IN side: snapshots an N-port controller report vector and streams one framed IN report per USB frame over a byte valid/ready handshake.
- OUT side: parses host OUT reports into per-port rumble bits, with frame-aligned byte counting and error flagging.
- Generalises the fixed 4-port / 37-byte adapter path to any port count and per-port payload size.

Parameters:
NUM_PORTS, 4, number of controller ports (1..8)
PORT_BYTES, 9, payload bytes per port in the IN report (1..16)
IN_REPORT_ID, 8'h21, first byte of every IN report
OUT_REPORT_ID, 8'h11, required first byte of a valid OUT rumble report
RUMBLE_TIMEOUT_FRAMES, 16, frames without a valid OUT report before rumble auto-clears (watchdog build only)
Derived: IN_LEN = 1 + NUM_PORTS*PORT_BYTES (default 37); OUT_LEN = 1 + NUM_PORTS (default 5)

Ports:
clk  in  1  clock
usb_rstn  in  1  reset
sof  in  1  one-cycle start-of-frame pulse from the USB core
report_data  in  NUM_PORTS*PORT_BYTES*8  controller payloads; port 0 in the MSBs, bytes MSB-first within a port
report_update  in  1  strobe: load report_data into the shadow buffer
ep_in_data  out  8  IN endpoint byte
ep_in_valid  out  1  IN byte valid
ep_in_ready  in  1  IN byte accepted by the core
ep_out_data  in  8  OUT endpoint byte
ep_out_valid  in  1  OUT byte strobe
rumble  out  NUM_PORTS  per-port rumble enable
in_busy  out  1  IN packet in progress
in_pkt_count  out  16  completed IN packets, wraps at 16'hFFFF->0
out_err  out  1  one-cycle pulse on a rejected OUT report

Behaviour:
- Reset is usb_rstn, asynchronous, active-low; clock is clk. All outputs reset to 0. Shadow buffer, snapshot, counters and FSM reset to 0 / IDLE.
- Shadow buffer: loaded from report_data on report_update in any state.
- IN FSM states: IDLE, SEND.
  - IDLE -> SEND on sof, or when pending=1.
    - On entry: snapshot <= shadow, byte index <= 0, pending cleared.
    - If report_update coincides with entry, snapshot takes report_data directly (bypass).
  - SEND: ep_in_valid=1 and in_busy=1.
    - Byte 0 = IN_REPORT_ID; bytes 1..IN_LEN-1 = snapshot, port 0 first.
    - ep_in_data holds stable until ep_in_valid && ep_in_ready; the index then advances next cycle.
    - Acceptance of byte IN_LEN-1: return to IDLE the next cycle, ep_in_valid=0, in_pkt_count+1.
  - sof during SEND: packet is not aborted; pending set; the next packet starts on the cycle after return to IDLE.
    - Multiple sof during one packet still yield a single pending packet.
  - The snapshot never changes during SEND; report_update during SEND affects the shadow only.
  - Reset mid-packet: ep_in_valid drops asynchronously; the partial packet is abandoned.
- OUT parser:
  - Byte counter clears on sof. Each ep_out_valid stores the byte at the counter position and increments; the counter saturates at OUT_LEN and extra bytes are ignored.
  - On the cycle the OUT_LEN-th byte is stored, evaluate the next cycle:
    - byte0 == OUT_REPORT_ID: rumble[i] <= bit 0 of byte i+1.
    - otherwise: out_err pulses for 1 cycle and rumble is unchanged.
  - Frame ending (sof) with fewer than OUT_LEN bytes: report discarded silently, rumble unchanged.
  - sof and ep_out_valid in the same cycle: the byte is stored as byte 0 of the new frame.
- IN and OUT paths are fully independent; simultaneous activity is legal.

Optional Feature:
Macro: HID_RUMBLE_WATCHDOG_EN
- Defined:
  - A frame counter increments on each sof, saturating at RUMBLE_TIMEOUT_FRAMES. It clears when a valid OUT report is applied.
  - On reaching RUMBLE_TIMEOUT_FRAMES, rumble <= 0 in the same cycle.
  - A valid report coinciding with the terminal sof wins: rumble updates and the counter clears.
- Not defined: the counter is not built; rumble holds its last value indefinitely until reset.

Test Plan:
- Reset, report_update with ports 0..3 = bytes 8'h10+k, sof, ep_in_ready=1 always -> 37 bytes: 8'h21, 8'h10..8'h33 in order; in_pkt_count=1; ep_in_valid low after the last byte.
- ep_in_ready toggling 1/0 each cycle -> each byte held while ready=0, no byte duplicated or skipped, 37 accepted bytes total.
- report_update with new data at byte 5 of a packet -> current packet keeps the old data; the next sof packet carries the new data.
- Two sof pulses mid-packet -> exactly one further packet starts the cycle after IDLE; in_pkt_count=2.
- OUT bytes 11,01,00,01,00 -> rumble=4'b0101. OUT bytes 12,01,01,01,01 -> out_err pulse, rumble unchanged. Three bytes then sof -> no change, no out_err.
- Watchdog build, rumble=4'b1111, 16 sof with no OUT -> rumble=0 at the 16th sof. Non-watchdog build, same stimulus -> rumble stays 4'b1111.
